// File: rtl/nubus_pkg.sv
// Shared encodings for the NuBus slot bridge: access sizes, bridge states and slot-space nibble.
package nubus_pkg;

  localparam logic [3:0] SLOT_SPACE = 4'hF;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_HI,
    ST_REL_HI,
    ST_REQ_LO,
    ST_REL_LO,
    ST_DONE,
    ST_ERR
  } bridge_state_e;

endpackage

// File: rtl/nubus_slot_bridge.sv
// CPU-to-NuBus minor-slot bridge: splits byte/word/long accesses into 16-bit select/ack_n
// card cycles, with per-edge timeout, bus error on misalignment, and a registered slot interrupt.
import nubus_pkg::*;

module nubus_slot_bridge #(
  parameter logic [3:0]  SLOT    = 4'hE,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpu_req_i,
  output logic        cpu_ready_o,
  input  logic [31:0] cpu_addr_i,
  input  logic [1:0]  cpu_size_i,
  input  logic        cpu_rw_n_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_berr_o,
  output logic [31:0] card_addr_o,
  output logic [15:0] card_wdata_o,
  output logic [1:0]  card_uds_lds_o,
  output logic        card_rw_n_o,
  output logic        card_select_o,
  input  logic [15:0] card_rdata_i,
  input  logic        card_ack_n_i,
  input  logic        card_nmrq_n_i,
  output logic        slot_irq_o
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  bridge_state_e state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        rw_q, rw_d;
  logic [15:0] wlo_q, wlo_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] card_addr_q, card_addr_d;
  logic [15:0] card_wdata_q, card_wdata_d;
  logic [1:0]  card_be_q, card_be_d;
  logic        card_rw_q, card_rw_d;
  logic        card_sel_q, card_sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        berr_q, berr_d;
  logic        ready_q;
  logic        irq_q;

  logic hit, is_long;
  assign hit     = cpu_addr_i[31:24] == {SLOT_SPACE, SLOT};
  assign is_long = size_q[1];

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    rw_d         = rw_q;
    wlo_d        = wlo_q;
    rbuf_d       = rbuf_q;
    timer_d      = timer_q;
    card_addr_d  = card_addr_q;
    card_wdata_d = card_wdata_q;
    card_be_d    = card_be_q;
    card_rw_d    = card_rw_q;
    card_sel_d   = card_sel_q;
    rdata_d      = rdata_q;
    ack_d        = 1'b0;
    berr_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_i && hit) begin
          size_d = cpu_size_i;
          rw_d   = cpu_rw_n_i;
          wlo_d  = cpu_wdata_i[15:0];
          rbuf_d = '0;
          if (cpu_size_i != SZ_BYTE && cpu_addr_i[0]) begin
            state_d = ST_ERR;
          end else begin
            state_d     = ST_REQ_HI;
            card_sel_d  = 1'b1;
            timer_d     = '0;
            card_addr_d = cpu_addr_i;
            card_rw_d   = cpu_rw_n_i;
            // Big-endian lanes: even byte rides on D[15:8] (uds), odd on D[7:0] (lds).
            case (cpu_size_i)
              SZ_BYTE: begin
                card_be_d    = cpu_addr_i[0] ? 2'b01 : 2'b10;
                card_wdata_d = {cpu_wdata_i[7:0], cpu_wdata_i[7:0]};
              end
              SZ_WORD: begin
                card_be_d    = 2'b11;
                card_wdata_d = cpu_wdata_i[15:0];
              end
              default: begin
                card_be_d    = 2'b11;
                card_wdata_d = cpu_wdata_i[31:16];
              end
            endcase
          end
        end
      end
      ST_REQ_HI, ST_REQ_LO: begin
        if (!card_ack_n_i) begin
          card_sel_d = 1'b0;
          timer_d    = '0;
          if (rw_q) begin
            if (state_q == ST_REQ_HI && is_long) rbuf_d[31:16] = card_rdata_i;
            else                                 rbuf_d[15:0]  = card_rdata_i;
          end
          state_d = (state_q == ST_REQ_HI) ? ST_REL_HI : ST_REL_LO;
        end else if (timer_q == TMO) begin
          card_sel_d = 1'b0;
          state_d    = ST_ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_REL_HI, ST_REL_LO: begin
        if (card_ack_n_i) begin
          if (state_q == ST_REL_HI && is_long) begin
            state_d      = ST_REQ_LO;
            card_sel_d   = 1'b1;
            timer_d      = '0;
            card_addr_d  = card_addr_q + 32'd2;
            card_wdata_d = wlo_q;
          end else begin
            state_d = ST_DONE;
          end
        end else if (timer_q == TMO) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_DONE: begin
        ack_d   = 1'b1;
        state_d = ST_IDLE;
        if (rw_q) begin
          case (size_q)
            SZ_BYTE: rdata_d = {24'b0, card_addr_q[0] ? rbuf_q[7:0] : rbuf_q[15:8]};
            SZ_WORD: rdata_d = {16'b0, rbuf_q[15:0]};
            default: rdata_d = rbuf_q;
          endcase
        end
      end
      ST_ERR: begin
        berr_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      size_q       <= SZ_BYTE;
      rw_q         <= 1'b1;
      wlo_q        <= '0;
      rbuf_q       <= '0;
      timer_q      <= '0;
      card_addr_q  <= '0;
      card_wdata_q <= '0;
      card_be_q    <= 2'b00;
      card_rw_q    <= 1'b1;
      card_sel_q   <= 1'b0;
      rdata_q      <= '0;
      ack_q        <= 1'b0;
      berr_q       <= 1'b0;
      ready_q      <= 1'b1;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      rw_q         <= rw_d;
      wlo_q        <= wlo_d;
      rbuf_q       <= rbuf_d;
      timer_q      <= timer_d;
      card_addr_q  <= card_addr_d;
      card_wdata_q <= card_wdata_d;
      card_be_q    <= card_be_d;
      card_rw_q    <= card_rw_d;
      card_sel_q   <= card_sel_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      berr_q       <= berr_d;
      ready_q      <= (state_d == ST_IDLE);
      irq_q        <= ~card_nmrq_n_i;
    end
  end

  assign cpu_ready_o    = ready_q;
  assign cpu_rdata_o    = rdata_q;
  assign cpu_ack_o      = ack_q;
  assign cpu_berr_o     = berr_q;
  assign card_addr_o    = card_addr_q;
  assign card_wdata_o   = card_wdata_q;
  assign card_uds_lds_o = card_be_q;
  assign card_rw_n_o    = card_rw_q;
  assign card_select_o  = card_sel_q;
  assign slot_irq_o     = irq_q;

endmodule

// File: tb/tb_nubus_slot_bridge.sv
// Bench for nubus_slot_bridge: transaction-level model of expected card cycles, completion timing
// and read data, checked every cycle, plus literal checks of the documented example transactions.
module tb_nubus_slot_bridge;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_ready;
  logic [31:0] cpu_addr = '0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_rw_n = 1'b1;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_berr;
  logic [31:0] card_addr;
  logic [15:0] card_wdata;
  logic [1:0]  card_be;
  logic        card_rw_n, card_select;
  logic [15:0] card_rdata;
  logic        card_ack_n = 1'b1;
  logic        card_nmrq_n = 1'b1;
  logic        slot_irq;

  nubus_slot_bridge #(.SLOT(4'hE), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .reset_i(reset), .cpu_req_i(cpu_req), .cpu_ready_o(cpu_ready),
    .cpu_addr_i(cpu_addr), .cpu_size_i(cpu_size), .cpu_rw_n_i(cpu_rw_n), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_berr_o(cpu_berr),
    .card_addr_o(card_addr), .card_wdata_o(card_wdata), .card_uds_lds_o(card_be),
    .card_rw_n_o(card_rw_n), .card_select_o(card_select), .card_rdata_i(card_rdata),
    .card_ack_n_i(card_ack_n), .card_nmrq_n_i(card_nmrq_n), .slot_irq_o(slot_irq)
  );

  always #5 clk = ~clk;

  // Card: acks one cycle after it sees select, releases one cycle after select drops.
  logic        noack = 1'b0;
  logic [15:0] resp_a = '0, resp_b = '0;
  always @(posedge clk) card_ack_n <= noack | ~card_select;
  assign card_rdata = card_addr[1] ? resp_b : resp_a;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int tests = 0, fails = 0;

  // Model of the transaction in flight
  logic        m_on = 1'b0;
  int          m_req_edge, m_end, m_halves;
  int          m_kind;               // 0 none, 1 ack, 2 berr
  logic        m_noack, m_rd;
  logic [31:0] m_rdata;
  logic [31:0] m_addr [2];
  logic [15:0] m_wd   [2];
  logic [1:0]  m_be   [2];

  logic [31:0] cap_addr [8];
  logic [15:0] cap_wd;
  logic [1:0]  cap_be;
  int          cap_n;
  logic        sel_prev;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] card_word(input logic [31:0] a);
    return a[1] ? resp_b : resp_a;
  endfunction

  task automatic compare_loop();
    int rel, h;
    logic sel_e;
    cap_n = 0;
    sel_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (card_select && !sel_prev && cap_n < 8) begin
        cap_addr[cap_n] = card_addr;
        cap_n++;
      end
      if (card_select) begin
        cap_wd = card_wdata;
        cap_be = card_be;
      end
      sel_prev = card_select;
      if (cpu_ack && cpu_berr) chk("ack_and_berr", 32'(1), 32'(0));
      if (m_on) begin
        rel = edge_n - m_req_edge;
        if (m_noack) begin
          sel_e = (m_halves > 0) && (rel <= TMO);
          h = 0;
        end else begin
          h = rel / 4;
          sel_e = (h < m_halves) && ((rel % 4) < 2);
        end
        chk("cpu_ack",   32'(cpu_ack),   32'(m_kind == 1 && rel == m_end));
        chk("cpu_berr",  32'(cpu_berr),  32'(m_kind == 2 && rel == m_end));
        chk("cpu_ready", 32'(cpu_ready), 32'(rel >= m_end));
        chk("card_select", 32'(card_select), 32'(sel_e));
        if (sel_e && card_select) begin
          chk("card_addr",  card_addr,        m_addr[h]);
          chk("card_wdata", 32'(card_wdata),  32'(m_wd[h]));
          chk("card_be",    32'(card_be),     32'(m_be[h]));
          chk("card_rw_n",  32'(card_rw_n),   32'(m_rd));
        end
        if (m_kind == 1 && m_rd && rel == m_end) chk("cpu_rdata", cpu_rdata, m_rdata);
      end
    end
  endtask

  // Builds the expectation from the access rules, then issues one request at the next edge.
  task automatic run_txn(input logic [31:0] a, input logic [1:0] sz, input logic rd,
                         input logic [31:0] wd, input logic [15:0] ra, input logic [15:0] rb,
                         input logic na);
    logic [15:0] d;
    @(negedge clk); #2;
    resp_a = ra; resp_b = rb; noack = na;
    m_noack = na; m_rd = rd;
    m_addr[0] = a; m_addr[1] = a + 32'd2;
    m_wd[1] = wd[15:0]; m_be[1] = 2'b11;
    d = card_word(a);
    if (sz == 2'b00) begin
      m_halves = 1; m_be[0] = a[0] ? 2'b01 : 2'b10; m_wd[0] = {wd[7:0], wd[7:0]};
      m_rdata = {24'b0, a[0] ? d[7:0] : d[15:8]};
    end else if (sz == 2'b01) begin
      m_halves = 1; m_be[0] = 2'b11; m_wd[0] = wd[15:0]; m_rdata = {16'b0, d};
    end else begin
      m_halves = 2; m_be[0] = 2'b11; m_wd[0] = wd[31:16]; m_rdata = {d, card_word(a + 32'd2)};
    end
    if (a[31:24] != 8'hFE) begin
      m_kind = 0; m_end = 0; m_halves = 0;
    end else if (sz != 2'b00 && a[0]) begin
      m_kind = 2; m_end = 1; m_halves = 0;
    end else if (na) begin
      m_kind = 2; m_end = TMO + 2;
    end else begin
      m_kind = 1; m_end = 4 * m_halves + 1;
    end
    m_req_edge = edge_n + 1;
    m_on = 1'b1;
    cpu_addr = a; cpu_size = sz; cpu_rw_n = rd; cpu_wdata = wd; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (m_end + 4) @(negedge clk);
    #2;
    m_on = 1'b0;
    noack = 1'b0;
  endtask

  initial begin
    int base;
    fork compare_loop(); join_none
    #12;
    chk("rst_ready",  32'(cpu_ready),   32'(1));
    chk("rst_select", 32'(card_select), 32'(0));
    chk("rst_rw_n",   32'(card_rw_n),   32'(1));
    chk("rst_be",     32'(card_be),     32'(0));
    chk("rst_ackberr", {30'b0, cpu_ack, cpu_berr}, 32'(0));
    chk("rst_rdata",  cpu_rdata, 32'(0));
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    // Word write
    base = cap_n;
    run_txn(32'hFE00_0100, 2'b01, 1'b0, 32'h0000_A55A, 16'h0, 16'h0, 1'b0);
    chk("ww_be",    32'(cap_be), 32'h3);
    chk("ww_wdata", 32'(cap_wd), 32'hA55A);
    chk("ww_addr",  cap_addr[base], 32'hFE00_0100);

    // Long read, split hi/lo
    base = cap_n;
    run_txn(32'hFE00_0000, 2'b10, 1'b1, 32'h0, 16'h1234, 16'h5678, 1'b0);
    chk("lr_rdata", cpu_rdata, 32'h1234_5678);
    chk("lr_addr0", cap_addr[base],     32'hFE00_0000);
    chk("lr_addr1", cap_addr[base + 1], 32'hFE00_0002);

    // Long write
    run_txn(32'hFE00_0012, 2'b10, 1'b0, 32'hDEAD_BEEF, 16'h0, 16'h0, 1'b0);
    // Size 11 behaves as long
    run_txn(32'hFE00_0020, 2'b11, 1'b1, 32'h0, 16'h0F0F, 16'hF00D, 1'b0);
    chk("l11_rdata", cpu_rdata, 32'h0F0F_F00D);

    // Byte write odd
    run_txn(32'hFE08_0001, 2'b00, 1'b0, 32'h0000_003C, 16'h0, 16'h0, 1'b0);
    chk("bw_be",    32'(cap_be), 32'h1);
    chk("bw_wdata", 32'(cap_wd), 32'h3C3C);
    // Byte write even
    run_txn(32'hFE08_0004, 2'b00, 1'b0, 32'h0000_0071, 16'h0, 16'h0, 1'b0);
    // Word read, addr[1]=1
    run_txn(32'hFE00_0102, 2'b01, 1'b1, 32'h0, 16'h1111, 16'hBEEF, 1'b0);
    chk("wr_rdata", cpu_rdata, 32'h0000_BEEF);
    // Byte read even then odd
    run_txn(32'hFE00_0010, 2'b00, 1'b1, 32'h0, 16'hABCD, 16'h0, 1'b0);
    chk("br_even", cpu_rdata, 32'h0000_00AB);
    run_txn(32'hFE00_0011, 2'b00, 1'b1, 32'h0, 16'hABCD, 16'h0, 1'b0);
    chk("br_odd", cpu_rdata, 32'h0000_00CD);

    // Misaligned word and long, then decode miss
    base = cap_n;
    run_txn(32'hFE00_0101, 2'b01, 1'b1, 32'h0, 16'h0, 16'h0, 1'b0);
    run_txn(32'hFE00_0203, 2'b10, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
    run_txn(32'hFD00_0000, 2'b01, 1'b1, 32'h0, 16'h0, 16'h0, 1'b0);
    chk("no_select", 32'(cap_n - base), 32'(0));
    chk("miss_rdata", cpu_rdata, 32'h0000_00CD);

    // Card never acks
    run_txn(32'hFE00_0200, 2'b01, 1'b1, 32'h0, 16'h7777, 16'h7777, 1'b1);
    chk("tmo_rdata", cpu_rdata, 32'h0000_00CD);

    // Request while busy is dropped
    run_txn(32'hFE00_0300, 2'b01, 1'b1, 32'h0, 16'h4242, 16'h0, 1'b0);

    // Async reset during a long read
    @(negedge clk);
    resp_a = 16'h1234; resp_b = 16'h5678;
    cpu_addr = 32'hFE00_0000; cpu_size = 2'b10; cpu_rw_n = 1'b1; cpu_req = 1'b1;
    @(posedge clk); #1 cpu_req = 1'b0;
    @(posedge clk); #3;
    chk("mid_select_pre", 32'(card_select), 32'(1));
    reset = 1'b1; #1;
    chk("mid_select_rst", 32'(card_select), 32'(0));
    chk("mid_ready_rst",  32'(cpu_ready),   32'(1));
    chk("mid_rw_rst",     32'(card_rw_n),   32'(1));
    @(negedge clk); reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'b0, cpu_ack, cpu_berr, card_select}, 32'(0));
    end

    // Slot interrupt follows nmrq_n with one edge of latency
    @(negedge clk); card_nmrq_n = 1'b0; #1;
    chk("irq_before", 32'(slot_irq), 32'(0));
    @(posedge clk); #1;
    chk("irq_set", 32'(slot_irq), 32'(1));
    @(negedge clk); card_nmrq_n = 1'b1;
    @(posedge clk); #1;
    chk("irq_clr", 32'(slot_irq), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Busy-drop stimulus: a second request pulsed while the previous access is in flight
  initial begin
    wait (m_on && m_addr[0] == 32'hFE00_0300);
    @(negedge clk); @(negedge clk); #3;
    cpu_addr = 32'hFE00_0400;
    cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_addr = 32'hFE00_0300;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
